// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared definitions for the programmable clock divider:
//   state_t    - divider run state (IDLE, RUN, STOP_PEND)
//   MIN_DIV    - smallest ratio the divider can produce
//   clamp_div  - maps a requested ratio onto the legal range (0 and 1 become MIN_DIV)
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    // Ratios below MIN_DIV cannot form a high and a low phase, so they are raised.
    function automatic logic [31:0] clamp_div(input logic [31:0] value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// clk_div_cnt
// Period counter for the clock divider. Counts 0..div-1 while count_en is high
// and produces the registered high phase (pos_q) and the rising-edge pulse.
// Ports:
//   clk_in    in   source clock
//   rst_n     in   asynchronous active-low reset
//   count_en  in   advance the counter on this edge; when low the counter parks at 0
//   div       in   ratio N in force for the current period
//   wrap      out  current edge ends the period (cnt == N-1 and counting)
//   pos_q     out  registered high phase, (cnt < N/2) using cnt before the increment
//   clk_rise  out  registered pulse, high for the cycle that starts each period
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic [DIV_W-1:0] div,
    output logic             wrap,
    output logic             pos_q,
    output logic             clk_rise
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half;

    assign half = div >> 1;
    assign wrap = count_en && (cnt == (div - DIV_W'(1)));

    // While stopped the counter is held at zero so the next enabled edge is
    // always the first edge of a fresh period.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pos_q    <= 1'b0;
            clk_rise <= 1'b0;
        end else if (count_en) begin
            pos_q    <= (cnt < half);
            clk_rise <= (cnt == '0);
            cnt      <= wrap ? '0 : cnt + DIV_W'(1);
        end else begin
            cnt      <= '0;
            pos_q    <= 1'b0;
            clk_rise <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog
// Programmable integer clock divider. clk_out has a period of N clk_in cycles,
// high for floor(N/2). Ratio updates and stops only take effect at period
// boundaries so clk_out never glitches.
// Optional build macro CLK_DIV_DUTY50_EN: adds a negedge flop so odd ratios
// get an exact 50% duty cycle (clk_out becomes the OR of two flops).
// Ports:
//   clk_in     in   source clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   run request, level sensitive
//   div_val    in   requested ratio N (0 and 1 are treated as 2)
//   div_load   in   load request, accepted only when div_ready is high
//   div_ready  out  no ratio pending; a load may be accepted
//   clk_out    out  divided clock
//   clk_rise   out  one clk_in cycle pulse coincident with each clk_out rise
//   busy       out  divider is running or finishing its last period
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ready,
    output logic             clk_out,
    output logic             clk_rise,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] pend_div;
    logic             pend_vld;
    logic             count_en;
    logic             wrap;
    logic             pos_q;

    // Leaving IDLE and counting happen on the same edge, so enable is folded
    // into the count enable to make that edge the first period edge.
    assign count_en  = (state != IDLE) || enable;
    assign busy      = (state != IDLE);
    assign div_ready = !pend_vld;

    clk_div_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .count_en (count_en),
        .div      (cur_div),
        .wrap     (wrap),
        .pos_q    (pos_q),
        .clk_rise (clk_rise)
    );

    // Run state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stop request lets the current period finish; enable returning before the
    // wrap keeps the period train unbroken. A stop sampled on the wrap edge ends
    // the run right at that boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = wrap ? IDLE : STOP_PEND;
                end
            end
            STOP_PEND: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ratio handshake. A pending ratio is applied at the wrap (or at once when
    // idle); a request arriving on that same edge is only captured, so the wrap
    // in progress never sees it. While a ratio is pending further loads are dropped.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur_div  <= DIV_W'(RESET_DIV);
            pend_div <= DIV_W'(RESET_DIV);
            pend_vld <= 1'b0;
        end else if (pend_vld && (wrap || (state == IDLE))) begin
            cur_div  <= pend_div;
            pend_vld <= 1'b0;
        end else if (div_load && !pend_vld) begin
            pend_div <= DIV_W'(clamp_div(32'(div_val)));
            pend_vld <= 1'b1;
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic neg_q;
    logic odd_q;

    // odd_q travels with pos_q so the half-cycle extension always follows the
    // ratio that produced the high phase, even across a ratio change.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= cur_div[0];
        end
    end

    // Half-cycle delayed copy of the high phase.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_out = pos_q | (neg_q & odd_q);
`else
    assign clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog
// Self-checking bench for clk_div_prog (DIV_W=8, RESET_DIV=2). Expected outputs
// come from a period-level reference model of the divider; a monitor compares
// them against the DUT one clk_in cycle at a time.
module tb_clk_div_prog;

    localparam int DIV_W = 8;

    typedef struct {
        logic clk_out;
        logic clk_rise;
        logic busy;
        logic div_ready;
    } exp_t;

    logic             clk_in;
    logic             rst_n;
    logic             enable;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             div_ready;
    logic             clk_out;
    logic             clk_rise;
    logic             busy;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    // Reference model: whether periods are being emitted, how many cycles of the
    // current period are done, the ratio and any pending ratio.
    bit m_active;
    int m_phase;
    int m_n;
    bit m_pend;
    int m_pend_n;
    bit m_pos_prev;

    clk_div_prog #(
        .DIV_W     (DIV_W),
        .RESET_DIV (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .enable    (enable),
        .div_val   (div_val),
        .div_load  (div_load),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .clk_rise  (clk_rise),
        .busy      (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        m_active   = 1'b0;
        m_phase    = 0;
        m_n        = 2;
        m_pend     = 1'b0;
        m_pend_n   = 2;
        m_pos_prev = 1'b0;
    endtask

    // One clk_in edge of the divider seen at period level.
    task automatic modelStep(input bit en, input bit ld, input int val, output exp_t e);
        bit ready_before;
        bit pos;
        bit rise;
        bit last;
        int n_used;
        ready_before = !m_pend;
        n_used       = m_n;
        if (!m_active) begin
            pos     = en;
            rise    = en;
            m_phase = en ? 1 : 0;
            if (m_pend) begin
                m_n    = m_pend_n;
                m_pend = 1'b0;
            end
            m_active = en;
        end else begin
            pos     = (m_phase < m_n / 2);
            rise    = (m_phase == 0);
            last    = (m_phase == m_n - 1);
            m_phase = last ? 0 : m_phase + 1;
            if (last && m_pend) begin
                m_n    = m_pend_n;
                m_pend = 1'b0;
            end
            m_active = en || !last;
        end
        if (ld && ready_before) begin
            m_pend   = 1'b1;
            m_pend_n = (val < 2) ? 2 : val;
        end
`ifdef CLK_DIV_DUTY50_EN
        e.clk_out = pos | (m_pos_prev & n_used[0]);
`else
        e.clk_out = pos;
`endif
        m_pos_prev  = pos;
        e.clk_rise  = rise;
        e.busy      = m_active;
        e.div_ready = !m_pend;
    endtask

    task automatic applyStimulus(input bit en, input bit ld, input int val);
        exp_t e;
        @(negedge clk_in);
        enable   = en;
        div_load = ld;
        div_val  = DIV_W'(val);
        modelStep(en, ld, val, e);
        sb.push_back(e);
    endtask

    // Asserts reset away from any clock edge and checks that outputs drop at once.
    task automatic pulseReset();
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_clk_out", clk_out, 1'b0);
        checkOutput("rst_clk_rise", clk_rise, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_div_ready", div_ready, 1'b1);
        enable   = 1'b0;
        div_load = 1'b0;
        repeat (2) @(negedge clk_in);
        checkOutput("rst_hold_busy", busy, 1'b0);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic runUntilPhase(input int target);
        int guard;
        guard = 0;
        while (m_phase != target && guard < 600) begin
            applyStimulus(1, 0, 0);
            guard++;
        end
        n_checks++;
        if (m_phase != target) begin
            n_fail++;
            $display("[TB] FAIL phase_wait: reached %0d required %0d", m_phase, target);
        end
    endtask

    // Monitor: the DUT presents a fresh output every clk_in cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("clk_out", clk_out, e.clk_out);
                checkOutput("clk_rise", clk_rise, e.clk_rise);
                checkOutput("busy", busy, e.busy);
                checkOutput("div_ready", div_ready, e.div_ready);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        modelReset();
        #2;
        checkOutput("init_clk_out", clk_out, 1'b0);
        checkOutput("init_busy", busy, 1'b0);
        checkOutput("init_div_ready", div_ready, 1'b1);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;

        $display("[TB] N=2 after reset");
        repeat (8) applyStimulus(1, 0, 0);

        $display("[TB] load 5 mid-period");
        applyStimulus(1, 1, 5);
        repeat (14) applyStimulus(1, 0, 0);

        $display("[TB] load 3 then 7 while busy with pending");
        runUntilPhase(2);
        applyStimulus(1, 1, 3);
        applyStimulus(1, 1, 7);
        repeat (12) applyStimulus(1, 0, 0);

        $display("[TB] N=4 stop and restart");
        applyStimulus(1, 1, 4);
        repeat (8) applyStimulus(1, 0, 0);
        runUntilPhase(1);
        repeat (6) applyStimulus(0, 0, 0);
        runUntilPhase(1);
        applyStimulus(0, 0, 0);
        repeat (9) applyStimulus(1, 0, 0);

        $display("[TB] clamp of 0 and 1");
        applyStimulus(1, 1, 0);
        repeat (8) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        repeat (8) applyStimulus(1, 0, 0);

        $display("[TB] stop and load on the same wrap");
        applyStimulus(1, 1, 6);
        runUntilPhase(5);
        applyStimulus(1, 1, 3);
        runUntilPhase(5);
        applyStimulus(0, 0, 0);
        repeat (8) applyStimulus(0, 0, 0);
        repeat (8) applyStimulus(1, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            bit en;
            bit ld;
            int v;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 12));
            applyStimulus(en, ld, v);
        end

        $display("[TB] N=255");
        applyStimulus(1, 1, 255);
        repeat (560) applyStimulus(1, 0, 0);

        $display("[TB] reset mid-period with a load pending");
        applyStimulus(1, 1, 9);
        applyStimulus(1, 0, 0);
        pulseReset();
        repeat (8) applyStimulus(1, 0, 0);

        @(posedge clk_in);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
